// File: rtl/io_pipe_register_pkg.sv
// Shared definitions for io_pipe_register: legal parameter ranges, the per-cycle
// stage operation and the Count width helper.
package io_pipe_register_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_SET   = 2'd2,
    OP_CLEAR = 2'd3
  } stage_op_e;

  // Bits needed to hold 0..d inclusive, i.e. clog2(d+1), never less than one.
  function automatic int count_width(input int d);
    int w;
    w = 1;
    while ((1 << w) < (d + 1)) w++;
    return w;
  endfunction

  // Clear outranks Set, which outranks Enable.
  function automatic stage_op_e decode_op(input logic clear, input logic set,
                                          input logic enable);
    if (clear)       return OP_CLEAR;
    else if (set)    return OP_SET;
    else if (enable) return OP_SHIFT;
    else             return OP_HOLD;
  endfunction

endpackage

// File: rtl/io_pipe_register_if.sv
// Control, data and status bundle of io_pipe_register; the master side drives the
// pipeline, the slave side is the pipeline itself.
interface io_pipe_register_if
  import io_pipe_register_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 2
) ();

  localparam int CW = count_width(depth);

  logic             Clear;
  logic             Set;
  logic             Enable;
  logic             InValid;
  logic [width-1:0] In;
  logic [width-1:0] Out;
  logic             OutValid;
  logic [CW-1:0]    Count;
  logic             Empty;

  modport master (
    output Clear, Set, Enable, InValid, In,
    input  Out, OutValid, Count, Empty
  );

  modport slave (
    input  Clear, Set, Enable, InValid, In,
    output Out, OutValid, Count, Empty
  );

endinterface

// File: rtl/io_pipe_stage.sv
// One pipeline stage: width data bits plus a valid flag, with synchronous clear,
// preset and enable. The last stage is marked for packing into the IO pad flop.
module io_pipe_stage
  import io_pipe_register_pkg::*;
#(
  parameter int               width      = 32,
  parameter logic [width-1:0] resetvalue = {width{1'b0}},
  parameter logic [width-1:0] setvalue   = {width{1'b1}},
  parameter bit               is_last    = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_clear,
  input  logic             i_set,
  input  logic             i_enable,
  input  logic [width-1:0] i_data,
  input  logic             i_valid,
  output logic [width-1:0] o_data,
  output logic             o_valid
);

  stage_op_e        w_op;
  logic [width-1:0] w_next_data;
  logic             w_next_valid;

  // NOTE: defaults first so every path assigns both signals; otherwise a latch is inferred.
  always_comb begin
    w_op         = decode_op(i_clear, i_set, i_enable);
    w_next_data  = o_data;
    w_next_valid = o_valid;
    case (w_op)
      OP_CLEAR: begin
        w_next_data  = resetvalue;
        w_next_valid = 1'b0;
      end
      OP_SET:   w_next_data = setvalue;
      OP_SHIFT: begin
        w_next_data  = i_data;
        w_next_valid = i_valid;
      end
      default: ;
    endcase
  end

  if (is_last) begin : g_pad
    (* IOB = "TRUE" *) logic [width:0] r_stage;

    // NOTE: non-blocking assignments in clocked blocks so all stages sample pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_stage <= {resetvalue, 1'b0};
      else        r_stage <= {w_next_data, w_next_valid};
    end

    assign {o_data, o_valid} = r_stage;
  end else begin : g_core
    logic [width:0] r_stage;

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_stage <= {resetvalue, 1'b0};
      else        r_stage <= {w_next_data, w_next_valid};
    end

    assign {o_data, o_valid} = r_stage;
  end

endmodule

// File: rtl/io_pipe_register.sv
// Parameterised IO pipeline register: depth stages of data+valid, plus a registered
// count of valid stages. All outputs come straight from flops or decode of flops.
module io_pipe_register
  import io_pipe_register_pkg::*;
#(
  parameter int               width      = 32,
  parameter int               depth      = 2,
  parameter logic [width-1:0] resetvalue = {width{1'b0}},
  parameter logic [width-1:0] setvalue   = {width{1'b1}}
) (
  input logic              Clock,
  input logic              Reset,
  io_pipe_register_if.slave bus
);

  localparam int            CW      = count_width(depth);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  if (depth < DEPTH_MIN || depth > DEPTH_MAX) begin : g_bad_depth
    $fatal(1, "io_pipe_register: depth out of range");
  end
  if (width < WIDTH_MIN || width > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "io_pipe_register: width out of range");
  end

  logic [width-1:0] w_in_data [depth];
  logic [depth-1:0] w_in_valid;
  logic [width-1:0] w_data    [depth];
  logic [depth-1:0] w_valid;
  stage_op_e        w_op;
  logic [CW-1:0]    r_count;

  assign w_in_data[0]  = bus.In;
  assign w_in_valid[0] = bus.InValid;

  for (genvar i = 0; i < depth; i++) begin : g_stage
    if (i > 0) begin : g_link
      assign w_in_data[i]  = w_data[i-1];
      assign w_in_valid[i] = w_valid[i-1];
    end

    io_pipe_stage #(
      .width      (width),
      .resetvalue (resetvalue),
      .setvalue   (setvalue),
      .is_last    (i == depth - 1)
    ) u_stage (
      .Clock    (Clock),
      .Reset    (Reset),
      .i_clear  (bus.Clear),
      .i_set    (bus.Set),
      .i_enable (bus.Enable),
      .i_data   (w_in_data[i]),
      .i_valid  (w_in_valid[i]),
      .o_data   (w_data[i]),
      .o_valid  (w_valid[i])
    );
  end

  assign w_op = decode_op(bus.Clear, bus.Set, bus.Enable);

  // Count tracks the valid shift: one in without one out grows it, and vice versa.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else begin
      case (w_op)
        OP_CLEAR: r_count <= '0;
        OP_SHIFT: begin
          if (bus.InValid && !w_valid[depth-1] && r_count != DEPTH_C)
            r_count <= r_count + 1'b1;
          else if (!bus.InValid && w_valid[depth-1] && r_count != '0)
            r_count <= r_count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Out      = w_data[depth-1];
  assign bus.OutValid = w_valid[depth-1];
  assign bus.Count    = r_count;
  assign bus.Empty    = (r_count == '0);

  a_count_matches_valids : assert property (
    @(posedge Clock) disable iff (!Reset) 32'(r_count) == $countones(w_valid)
  );

endmodule

// File: tb/tb_io_pipe_register.sv
// Self-checking bench for io_pipe_register (width=8, depth=3): directed scenarios
// followed by random traffic, all compared against an array-based reference model.
module tb_io_pipe_register;

  localparam int W = 8;
  localparam int D = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  io_pipe_register_if #(.width(W), .depth(D)) bus ();

  io_pipe_register #(.width(W), .depth(D)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_data  [D];
  logic         m_valid [D];

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m_valid[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_data[i]  = 8'h00;
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic c, input logic s, input logic e,
                            input logic v, input logic [W-1:0] d);
    if (c) begin
      model_reset();
    end else if (s) begin
      for (int i = 0; i < D; i++) m_data[i] = 8'hFF;
    end else if (e) begin
      for (int i = D - 1; i > 0; i--) begin
        m_data[i]  = m_data[i-1];
        m_valid[i] = m_valid[i-1];
      end
      m_data[0]  = d;
      m_valid[0] = v;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int c;
    c = model_count();
    check({tag, "_out"},      64'(bus.Out),      64'(m_data[D-1]));
    check({tag, "_outvalid"}, 64'(bus.OutValid), 64'(m_valid[D-1]));
    check({tag, "_count"},    64'(bus.Count),    64'(c));
    check({tag, "_empty"},    64'(bus.Empty),    64'(c == 0));
  endtask

  // Drive at the falling edge, let one rising edge act, compare at the next falling edge.
  task automatic step(input string tag, input logic c, input logic s, input logic e,
                      input logic v, input logic [W-1:0] d);
    bus.Clear   = c;
    bus.Set     = s;
    bus.Enable  = e;
    bus.InValid = v;
    bus.In      = d;
    @(posedge Clock);
    if (Reset) model_edge(c, s, e, v, d);
    else       model_reset();
    @(negedge Clock);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    bus.Clear = 1'b0; bus.Set = 1'b0; bus.Enable = 1'b0; bus.InValid = 1'b0; bus.In = '0;
    @(negedge Clock);

    // Held in reset with live-looking inputs: outputs stay at reset state.
    for (int i = 0; i < 5; i++) step("reset_hold", 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
    Reset = 1'b1;

    // Basic fill: first datum reaches Out on the third enabled edge.
    step("fill1", 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    step("fill2", 1'b0, 1'b0, 1'b1, 1'b1, 8'h22);
    step("fill3", 1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
    check("fill3_out_const",   64'(bus.Out),      64'h11);
    check("fill3_count_const", 64'(bus.Count),    64'd3);
    check("fill3_valid_const", 64'(bus.OutValid), 64'd1);
    step("fill4", 1'b0, 1'b0, 1'b1, 1'b0, 8'h44);
    check("fill4_out_const",   64'(bus.Out),      64'h22);

    // Stalls stretch but never drop or duplicate data.
    step("flush", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step("stall_in", 1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    for (int i = 0; i < 4; i++) step("stall", 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
    step("stall_go1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h66);
    check("stall_go1_notyet", 64'(bus.OutValid), 64'd0);
    step("stall_go2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
    check("stall_go2_out_const", 64'(bus.Out),      64'h11);
    check("stall_go2_vld_const", 64'(bus.OutValid), 64'd1);
    step("stall_go3", 1'b0, 1'b0, 1'b1, 1'b0, 8'h88);
    check("stall_go3_no_dup", 64'(bus.OutValid), 64'd0);

    // Set on a full pipe: data preset, valids and Count kept, In discarded.
    step("full_a", 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);
    step("full_b", 1'b0, 1'b0, 1'b1, 1'b1, 8'hBB);
    step("full_c", 1'b0, 1'b0, 1'b1, 1'b1, 8'hCC);
    step("set_full", 1'b0, 1'b1, 1'b1, 1'b1, 8'hDD);
    check("set_out_const",   64'(bus.Out),      64'hFF);
    check("set_count_const", 64'(bus.Count),    64'd3);
    check("set_valid_const", 64'(bus.OutValid), 64'd1);
    step("after_set", 1'b0, 1'b0, 1'b1, 1'b0, 8'h01);
    check("after_set_out_const", 64'(bus.Out), 64'hFF);

    // Clear beats Set.
    step("refill", 1'b0, 1'b0, 1'b1, 1'b1, 8'h12);
    step("clr_set", 1'b1, 1'b1, 1'b1, 1'b1, 8'h34);
    check("clr_set_out_const",   64'(bus.Out),   64'h00);
    check("clr_set_count_const", 64'(bus.Count), 64'd0);
    check("clr_set_empty_const", 64'(bus.Empty), 64'd1);

    // Alternating valid: Count settles between one and two.
    for (int i = 0; i < 10; i++)
      step("alt", 1'b0, 1'b0, 1'b1, logic'(i % 2 == 0), 8'(i * 7));
    check("alt_count_range", 64'(bus.Count >= 1 && bus.Count <= 2), 64'd1);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step("rand", logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 14) == 0),
           logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
           8'($urandom));

    // Reset mid-stream takes effect asynchronously and discards everything.
    step("pre_rst_a", 1'b0, 1'b0, 1'b1, 1'b1, 8'h9A);
    step("pre_rst_b", 1'b0, 1'b0, 1'b1, 1'b1, 8'h9B);
    step("pre_rst_c", 1'b0, 1'b0, 1'b1, 1'b1, 8'h9C);
    #2 Reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    step("in_rst", 1'b0, 1'b0, 1'b1, 1'b1, 8'hEE);
    Reset = 1'b1;
    step("post_rst1", 1'b0, 1'b0, 1'b1, 1'b1, 8'h21);
    step("post_rst2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    step("post_rst3", 1'b0, 1'b0, 1'b1, 1'b1, 8'h23);
    check("post_rst_out_const", 64'(bus.Out), 64'h21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
